// File: rtl/sh_ubc_nch_pkg.sv
// Shared types, register init/mask constants and byte-merge helpers for the
// N-channel SH user break controller.
package sh_ubc_nch_pkg;

    localparam int UBC_CH_STRIDE = 16;

    // Break bus cycle register: only the low byte holds fields, upper byte reads 0.
    typedef struct packed {
        logic [7:0] rsvd;
        logic [1:0] cd;
        logic [1:0] id;
        logic [1:0] rw;
        logic [1:0] sz;
    } UBC_BBR_t;

    typedef struct packed {
        logic [7:0] cmf;
        logic [5:0] rsvd;
        logic       arm;
        logic       seq;
    } BRCR_t;

    localparam logic [31:0] BAR_INIT   = 32'h0000_0000;
    localparam logic [31:0] BAMR_INIT  = 32'h0000_0000;
    localparam logic [31:0] BAMR_WMASK = 32'hFFFF_FFFF;
    localparam logic [31:0] BAMR_RMASK = 32'hFFFF_FFFF;
    localparam logic [15:0] BBR_INIT   = 16'h0000;
    localparam logic [15:0] BBR_WMASK  = 16'h00FF;
    localparam logic [15:0] BBR_RMASK  = 16'h00FF;
    localparam logic [15:0] BRCR_INIT  = 16'h0000;
    localparam logic [15:0] BRCR_WMASK = 16'hFF01;
    localparam logic [15:0] BRCR_RMASK = 16'hFF03;

    // BAR write/read mask: only the compared address bits exist.
    function automatic logic [31:0] f_bar_mask(input int aw);
        logic [31:0] m;
        for (int i = 0; i < 32; i++) begin
            m[i] = (i < aw);
        end
        return m;
    endfunction

    function automatic logic [31:0] f_byte_merge(input logic [31:0] old_v,
                                                 input logic [31:0] di,
                                                 input logic [3:0]  ba,
                                                 input logic [31:0] wmask);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = ba[b] ? wmask[b*8 +: 8] : 8'h00;
        end
        return (old_v & ~m) | (di & m);
    endfunction

    // Registers living in the upper half of their word see only BA[3:2].
    function automatic logic [15:0] f_merge_hi(input logic [15:0] old_v,
                                               input logic [15:0] di,
                                               input logic [1:0]  ba,
                                               input logic [15:0] wmask);
        logic [15:0] m;
        m[15:8] = ba[1] ? wmask[15:8] : 8'h00;
        m[7:0]  = ba[0] ? wmask[7:0]  : 8'h00;
        return (old_v & ~m) | (di & m);
    endfunction

endpackage

// File: rtl/sh_ubc_nch_cmp.sv
// Single break channel comparator: combinational HIT from one channel's
// BAR/BAMR/BBR against the snooped bus cycle.
module sh_ubc_cmp
    import sh_ubc_nch_pkg::*;
#(
    parameter int ADDR_W = 28
) (
    input  logic [ADDR_W-1:0] i_bar,
    input  logic [ADDR_W-1:0] i_bamr,
    input  logic [1:0]        i_cd,
    input  logic [1:0]        i_id,
    input  logic [1:0]        i_rw,
    input  logic [1:0]        i_sz,
    input  logic [ADDR_W-1:0] i_mon_a,
    input  logic              i_mon_valid,
    input  logic              i_mon_we,
    input  logic [1:0]        i_mon_sz,
    input  logic              i_mon_if,
    input  logic              i_mon_dma,
    output logic              o_hit
);

    logic w_addr_ok;
    logic w_cd_ok;
    logic w_id_ok;
    logic w_rw_ok;
    logic w_sz_ok;

    // A 2'b00 qualifier field matches neither polarity, which disables the channel.
    assign w_addr_ok = (((i_mon_a ^ i_bar) & ~i_bamr) == '0);
    assign w_cd_ok   = i_mon_dma ? i_cd[1] : i_cd[0];
    assign w_id_ok   = i_mon_if  ? i_id[0] : i_id[1];
    assign w_rw_ok   = i_mon_we  ? i_rw[1] : i_rw[0];
    assign w_sz_ok   = (i_sz == 2'b00) || (i_sz == i_mon_sz);

    assign o_hit = i_mon_valid & w_addr_ok & w_cd_ok & w_id_ok & w_rw_ok & w_sz_ok;

endmodule

// File: rtl/sh_ubc_nch.sv
// N-channel user break controller: IBUS register file, per-channel bus
// snooping comparators, sticky match flags, A-then-B sequencing and IRQ.
module sh_ubc_nch
    import sh_ubc_nch_pkg::*;
#(
    parameter int                CH       = 2,
    parameter int                ADDR_W   = 28,
    parameter logic [ADDR_W-1:0] REG_BASE = 28'h5FFFF90
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE_R,
    input  logic              CE_F,
    input  logic              RES_N,
    input  logic [ADDR_W-1:0] IBUS_A,
    input  logic [31:0]       IBUS_DI,
    output logic [31:0]       IBUS_DO,
    input  logic [3:0]        IBUS_BA,
    input  logic              IBUS_WE,
    input  logic              IBUS_REQ,
    output logic              IBUS_BUSY,
    output logic              IBUS_ACT,
    input  logic [ADDR_W-1:0] MON_A,
    input  logic              MON_VALID,
    input  logic              MON_WE,
    input  logic [1:0]        MON_SZ,
    input  logic              MON_IF,
    input  logic              MON_DMA,
    output logic              IRQ
);

    localparam int                IDX_W     = ADDR_W - 4;
    localparam logic [ADDR_W-1:0] WIN_END   = REG_BASE + ADDR_W'(UBC_CH_STRIDE * CH + 3);
    localparam logic [31:0]       BAR_WMASK = f_bar_mask(ADDR_W);

    logic [31:0]       r_bar  [CH];
    logic [31:0]       r_bamr [CH];
    UBC_BBR_t          r_bbr  [CH];
    logic [CH-1:0]     r_cmf;
    logic              r_arm;
    logic              r_seq;
    logic [31:0]       r_do;

    logic              w_init;
    logic              w_reg_sel;
    logic [ADDR_W-1:0] w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [1:0]        w_sub;
    logic              w_unused_ok;
    logic              w_wr;
    logic              w_brcr_sel;
    logic              w_seq_wr;
    logic [CH-1:0]     w_hit;
    logic [CH-1:0]     w_set;
    logic [CH-1:0]     w_clr;
    logic              w_arm_nxt;
    logic [CH-1:0]     w_irq_mask;
    logic [7:0]        w_cmf8;
    BRCR_t             w_brcr;
    logic [31:0]       w_rdata;

    assign w_init     = RST | (CE_R & ~RES_N);
    assign w_reg_sel  = (IBUS_A >= REG_BASE) && (IBUS_A <= WIN_END);
    assign w_off      = IBUS_A - REG_BASE;
    assign w_idx      = w_off[ADDR_W-1:4];
    assign w_sub      = w_off[3:2];
    assign w_unused_ok = &{1'b0, w_off[1:0]};
    assign w_wr       = CE_R & w_reg_sel & IBUS_WE & IBUS_REQ;
    assign w_brcr_sel = (w_idx == IDX_W'(CH)) && (w_sub == 2'd0);
    assign w_seq_wr   = w_wr & w_brcr_sel & IBUS_BA[2];

    assign IBUS_BUSY = 1'b0;
    assign IBUS_ACT  = w_reg_sel & IBUS_REQ;
    assign IBUS_DO   = r_do;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        sh_ubc_cmp #(
            .ADDR_W (ADDR_W)
        ) u_cmp (
            .i_bar       (r_bar[g][ADDR_W-1:0]),
            .i_bamr      (r_bamr[g][ADDR_W-1:0]),
            .i_cd        (r_bbr[g].cd),
            .i_id        (r_bbr[g].id),
            .i_rw        (r_bbr[g].rw),
            .i_sz        (r_bbr[g].sz),
            .i_mon_a     (MON_A),
            .i_mon_valid (MON_VALID),
            .i_mon_we    (MON_WE),
            .i_mon_sz    (MON_SZ),
            .i_mon_if    (MON_IF),
            .i_mon_dma   (MON_DMA),
            .o_hit       (w_hit[g])
        );
    end

    // Sequential mode gates channel 1 on an ARM that was set on an earlier edge.
    if (CH >= 2) begin : g_seq
        always_comb begin
            w_set     = w_hit;
            w_arm_nxt = r_arm;
            if (r_seq) begin
                w_set[1]  = w_hit[1] & r_arm;
                w_arm_nxt = w_hit[0] ? 1'b1 : (w_set[1] ? 1'b0 : r_arm);
            end
        end
    end else begin : g_noseq
        assign w_set     = w_hit;
        assign w_arm_nxt = 1'b0;
    end

    // Flags clear only on a written 0; a concurrent hit still wins below.
    assign w_clr = (w_wr & w_brcr_sel & IBUS_BA[3]) ? ~IBUS_DI[24 +: CH] : '0;

    always_comb begin
        w_irq_mask = '1;
        if (r_seq && (CH >= 2)) begin
            w_irq_mask[0] = 1'b0;
        end
    end

    assign IRQ = |(r_cmf & w_irq_mask);

    always_comb begin
        w_cmf8         = 8'h00;
        w_cmf8[CH-1:0] = r_cmf;
    end

    assign w_brcr = BRCR_t'{cmf: w_cmf8, rsvd: 6'd0, arm: r_arm, seq: r_seq};

    always_comb begin
        w_rdata = 32'h0;
        for (int n = 0; n < CH; n++) begin
            if (w_idx == IDX_W'(n)) begin
                case (w_sub)
                    2'd0:    w_rdata = r_bar[n];
                    2'd1:    w_rdata = r_bamr[n] & BAMR_RMASK;
                    2'd2:    w_rdata = {r_bbr[n] & BBR_RMASK, 16'h0000};
                    default: w_rdata = 32'h0;
                endcase
            end
        end
        if (w_brcr_sel) begin
            w_rdata = {w_brcr & BRCR_RMASK, 16'h0000};
        end
    end

    // Register file, flags and sequencing update on the rising phase
    always_ff @(posedge CLK) begin
        if (w_init) begin
            for (int n = 0; n < CH; n++) begin
                r_bar[n]  <= BAR_INIT;
                r_bamr[n] <= BAMR_INIT;
                r_bbr[n]  <= BBR_INIT;
            end
            r_cmf <= '0;
            r_arm <= BRCR_INIT[1];
            r_seq <= BRCR_INIT[0];
        end else if (CE_R) begin
            for (int n = 0; n < CH; n++) begin
                if (w_wr && (w_idx == IDX_W'(n))) begin
                    case (w_sub)
                        2'd0:    r_bar[n]  <= f_byte_merge(r_bar[n], IBUS_DI, IBUS_BA, BAR_WMASK);
                        2'd1:    r_bamr[n] <= f_byte_merge(r_bamr[n], IBUS_DI, IBUS_BA, BAMR_WMASK);
                        2'd2:    r_bbr[n]  <= f_merge_hi(r_bbr[n], IBUS_DI[31:16], IBUS_BA[3:2], BBR_WMASK);
                        default: ;
                    endcase
                end
            end
            r_cmf <= (r_cmf & ~w_clr) | w_set;
            if (w_seq_wr) begin
                r_seq <= IBUS_DI[16] & BRCR_WMASK[0];
                r_arm <= 1'b0;
            end else begin
                r_arm <= w_arm_nxt;
            end
        end
    end

    // Read data captured on the falling phase
    always_ff @(posedge CLK) begin
        if (w_init) begin
            r_do <= 32'h0;
        end else if (CE_F) begin
            r_do <= (w_reg_sel & IBUS_REQ & ~IBUS_WE) ? w_rdata : 32'h0;
        end
    end

endmodule

// File: tb/tb_sh_ubc_nch.sv
// Directed self-checking bench for sh_ubc_nch (CH=2, ADDR_W=28).
module tb_sh_ubc_nch;

    localparam logic [27:0] A_BAR0  = 28'h5FFFF90;
    localparam logic [27:0] A_BAMR0 = 28'h5FFFF94;
    localparam logic [27:0] A_BBR0  = 28'h5FFFF98;
    localparam logic [27:0] A_UNMAP = 28'h5FFFF9C;
    localparam logic [27:0] A_BAR1  = 28'h5FFFFA0;
    localparam logic [27:0] A_BAMR1 = 28'h5FFFFA4;
    localparam logic [27:0] A_BBR1  = 28'h5FFFFA8;
    localparam logic [27:0] A_BRCR  = 28'h5FFFFB0;

    logic        CLK = 1'b0;
    logic        RST, CE_R, CE_F, RES_N;
    logic [27:0] IBUS_A;
    logic [31:0] IBUS_DI;
    logic [31:0] IBUS_DO;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE, IBUS_REQ, IBUS_BUSY, IBUS_ACT;
    logic [27:0] MON_A;
    logic        MON_VALID, MON_WE, MON_IF, MON_DMA;
    logic [1:0]  MON_SZ;
    logic        IRQ;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] rd_v;

    always #5 CLK = ~CLK;

    sh_ubc_nch #(.CH(2), .ADDR_W(28), .REG_BASE(28'h5FFFF90)) dut (
        .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F), .RES_N(RES_N),
        .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI), .IBUS_DO(IBUS_DO), .IBUS_BA(IBUS_BA),
        .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT),
        .MON_A(MON_A), .MON_VALID(MON_VALID), .MON_WE(MON_WE), .MON_SZ(MON_SZ),
        .MON_IF(MON_IF), .MON_DMA(MON_DMA), .IRQ(IRQ)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [27:0] a, input logic [31:0] d, input logic [3:0] ba);
        IBUS_A = a; IBUS_DI = d; IBUS_BA = ba; IBUS_WE = 1'b1; IBUS_REQ = 1'b1;
        @(posedge CLK); #1;
        IBUS_WE = 1'b0; IBUS_REQ = 1'b0;
    endtask

    task automatic rd(input logic [27:0] a, output logic [31:0] d);
        IBUS_A = a; IBUS_WE = 1'b0; IBUS_REQ = 1'b1;
        @(posedge CLK); #1;
        d = IBUS_DO;
        IBUS_REQ = 1'b0;
    endtask

    task automatic mon_set(input logic [27:0] a, input logic we, input logic [1:0] sz,
                           input logic ifc, input logic dma);
        MON_A = a; MON_WE = we; MON_SZ = sz; MON_IF = ifc; MON_DMA = dma; MON_VALID = 1'b1;
    endtask

    task automatic mon(input logic [27:0] a, input logic we, input logic [1:0] sz,
                       input logic ifc, input logic dma);
        mon_set(a, we, sz, ifc, dma);
        @(posedge CLK); #1;
        MON_VALID = 1'b0;
    endtask

    // IBUS write and snooped cycle presented on the same edge
    task automatic wrmon(input logic [27:0] wa, input logic [31:0] d, input logic [3:0] ba,
                         input logic [27:0] ma);
        IBUS_A = wa; IBUS_DI = d; IBUS_BA = ba; IBUS_WE = 1'b1; IBUS_REQ = 1'b1;
        mon_set(ma, 1'b0, 2'b11, 1'b0, 1'b0);
        @(posedge CLK); #1;
        IBUS_WE = 1'b0; IBUS_REQ = 1'b0; MON_VALID = 1'b0;
    endtask

    initial begin
        RST = 1'b1; CE_R = 1'b1; CE_F = 1'b1; RES_N = 1'b1;
        IBUS_A = '0; IBUS_DI = '0; IBUS_BA = '0; IBUS_WE = 1'b0; IBUS_REQ = 1'b0;
        MON_A = '0; MON_VALID = 1'b0; MON_WE = 1'b0; MON_SZ = 2'b00; MON_IF = 1'b0; MON_DMA = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        chk("rst_irq", {31'd0, IRQ}, 32'd0);
        chk("rst_do", IBUS_DO, 32'd0);
        chk("busy", {31'd0, IBUS_BUSY}, 32'd0);
        rd(A_BAR0, rd_v); chk("rst_bar0", rd_v, 32'd0);
        rd(A_BRCR, rd_v); chk("rst_brcr", rd_v, 32'd0);

        // Basic any-cycle break on channel 0
        wr(A_BAR0, 32'h0000_1000, 4'hF);
        wr(A_BAMR0, 32'h0, 4'hF);
        wr(A_BBR0, 32'hFFFF_0000, 4'hF);
        rd(A_BBR0, rd_v); chk("bbr_hi_ro", rd_v, 32'h00FF_0000);
        rd(A_BAR0, rd_v); chk("bar0_rd", rd_v, 32'h0000_1000);
        mon(28'h0001000, 1'b0, 2'b11, 1'b0, 1'b0);
        chk("hit_irq", {31'd0, IRQ}, 32'd1);
        rd(A_BRCR, rd_v); chk("hit_cmf0", rd_v, 32'h0100_0000);
        wr(A_BRCR, 32'h0, 4'b1000);
        chk("clr_irq", {31'd0, IRQ}, 32'd0);

        // Address mask
        wr(A_BAMR0, 32'h0000_00FF, 4'hF);
        mon(28'h00010AB, 1'b0, 2'b11, 1'b0, 1'b0);
        chk("mask_hit", {31'd0, IRQ}, 32'd1);
        wr(A_BRCR, 32'h0, 4'b1000);
        mon(28'h0001100, 1'b0, 2'b11, 1'b0, 1'b0);
        chk("mask_miss", {31'd0, IRQ}, 32'd0);

        // Direction and size qualifiers: word writes only
        wr(A_BBR0, 32'h00FA_0000, 4'b0100);
        mon(28'h0001000, 1'b1, 2'b10, 1'b0, 1'b0);
        chk("word_wr_hit", {31'd0, IRQ}, 32'd1);
        wr(A_BRCR, 32'h0, 4'b1000);
        mon(28'h0001000, 1'b1, 2'b11, 1'b0, 1'b0);
        chk("long_wr_miss", {31'd0, IRQ}, 32'd0);
        mon(28'h0001000, 1'b0, 2'b01, 1'b0, 1'b0);
        chk("byte_rd_miss", {31'd0, IRQ}, 32'd0);

        // Master and fetch qualifiers: CPU long fetches only
        wr(A_BBR0, 32'h005F_0000, 4'b0100);
        mon(28'h0001000, 1'b0, 2'b11, 1'b1, 1'b0);
        chk("cpu_if_hit", {31'd0, IRQ}, 32'd1);
        wr(A_BRCR, 32'h0, 4'b1000);
        mon(28'h0001000, 1'b0, 2'b11, 1'b1, 1'b1);
        chk("dma_miss", {31'd0, IRQ}, 32'd0);
        mon(28'h0001000, 1'b0, 2'b11, 1'b0, 1'b0);
        chk("data_miss", {31'd0, IRQ}, 32'd0);

        // Sequential A-then-B
        wr(A_BAMR0, 32'h0, 4'hF);
        wr(A_BBR0, 32'h00FF_0000, 4'b0100);
        wr(A_BAR1, 32'h0000_2000, 4'hF);
        wr(A_BAMR1, 32'h0, 4'hF);
        wr(A_BBR1, 32'h00FF_0000, 4'b0100);
        wr(A_BRCR, 32'h0001_0000, 4'b1100);
        rd(A_BRCR, rd_v); chk("seq_on", rd_v, 32'h0001_0000);
        mon(28'h0002000, 1'b0, 2'b11, 1'b0, 1'b0);
        rd(A_BRCR, rd_v); chk("seq_b_first", rd_v, 32'h0001_0000);
        chk("seq_b_first_irq", {31'd0, IRQ}, 32'd0);
        mon(28'h0001000, 1'b0, 2'b11, 1'b0, 1'b0);
        chk("seq_a_irq", {31'd0, IRQ}, 32'd0);
        rd(A_BRCR, rd_v); chk("seq_a_arm", rd_v, 32'h0103_0000);
        mon(28'h0002000, 1'b0, 2'b11, 1'b0, 1'b0);
        chk("seq_b_irq", {31'd0, IRQ}, 32'd1);
        rd(A_BRCR, rd_v); chk("seq_b_cmf", rd_v, 32'h0301_0000);

        // Same-edge flag clear vs hit: set wins
        wr(A_BRCR, 32'h0, 4'b1100);
        chk("seq_off_irq", {31'd0, IRQ}, 32'd0);
        wrmon(A_BRCR, 32'h0, 4'b1000, 28'h0001000);
        chk("clr_vs_hit_irq", {31'd0, IRQ}, 32'd1);
        rd(A_BRCR, rd_v); chk("clr_vs_hit_cmf", rd_v, 32'h0100_0000);

        // BAR write on the same edge as a cycle compares against the old BAR
        wr(A_BRCR, 32'h0, 4'b1000);
        wrmon(A_BAR0, 32'h0000_3000, 4'hF, 28'h0001000);
        chk("old_bar_hit", {31'd0, IRQ}, 32'd1);
        wr(A_BRCR, 32'h0, 4'b1000);
        mon(28'h0001000, 1'b0, 2'b11, 1'b0, 1'b0);
        chk("new_bar_miss", {31'd0, IRQ}, 32'd0);
        mon(28'h0003000, 1'b0, 2'b11, 1'b0, 1'b0);
        chk("new_bar_hit", {31'd0, IRQ}, 32'd1);
        wr(A_BRCR, 32'h0, 4'b1000);

        // Byte lanes and address width
        wr(A_BAR0, 32'h0, 4'hF);
        wr(A_BAR0, 32'hAABB_CCDD, 4'b0100);
        rd(A_BAR0, rd_v); chk("bar_byte2", rd_v, 32'h00BB_0000);
        wr(A_BAR0, 32'hAABB_CCDD, 4'hF);
        rd(A_BAR0, rd_v); chk("bar_width", rd_v, 32'h0ABB_CCDD);
        rd(A_UNMAP, rd_v); chk("unmapped", rd_v, 32'h0);

        // Window edges
        IBUS_A = 28'h5FFFFB4; IBUS_REQ = 1'b1; #1;
        chk("act_out", {31'd0, IBUS_ACT}, 32'd0);
        IBUS_A = 28'h5FFFFB3; #1;
        chk("act_in", {31'd0, IBUS_ACT}, 32'd1);
        IBUS_REQ = 1'b0;
        rd(28'h5FFFFB4, rd_v); chk("out_win_rd", rd_v, 32'h0);

        // Soft reset mid-sequence
        wr(A_BAR0, 32'h0000_1000, 4'hF);
        wr(A_BRCR, 32'h0001_0000, 4'b1100);
        mon(28'h0001000, 1'b0, 2'b11, 1'b0, 1'b0);
        rd(A_BRCR, rd_v); chk("pre_res_arm", rd_v, 32'h0103_0000);
        RES_N = 1'b0;
        @(posedge CLK); #1;
        RES_N = 1'b1;
        chk("res_irq", {31'd0, IRQ}, 32'd0);
        chk("res_do", IBUS_DO, 32'd0);
        rd(A_BRCR, rd_v); chk("res_brcr", rd_v, 32'h0);
        rd(A_BAR0, rd_v); chk("res_bar0", rd_v, 32'h0);
        rd(A_BBR0, rd_v); chk("res_bbr0", rd_v, 32'h0);
        rd(A_BAR1, rd_v); chk("res_bar1", rd_v, 32'h0);
        mon(28'h0000000, 1'b0, 2'b11, 1'b0, 1'b0);
        chk("disabled_miss", {31'd0, IRQ}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
